unified_mem_arbiter: RTL and testbench

- Shares one synchronous single-port memory between the core's instruction-fetch path and its load/store path.
- Arbitrates between the two requesters, issues one memory access at a time, and waits a fixed read latency.
- Returns read data to the winner with a one-cycle valid pulse.
- Sits between the core's pc/instruction and alu_addr/mem_we_in/rs2_val_sx/mem_out signals and the shared memory macro.

---
 rtl/unified_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: one single-port memory shared by instruction fetch and
// load/store. One access in flight at a time, fixed read latency, one-cycle
// valid pulse back to whichever requester won arbitration.
//
// state | meaning
// IDLE  | no access in flight; arbitrates on the sampled requests
// ISSUE | mem_en high for the granted access (one cycle)
// WAIT  | counting down the memory read latency, captures mem_rdata at zero
// RESP  | owner's valid pulse is high; requests ignored

module unified_mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [1:0]      LAT_INIT   = 2'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          grant;
    logic          grant_if;
    logic [1:0]    lat_cnt_q;
    logic [SW-1:0] starve_q;
    logic          owner_if_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and arbitration decision. Data wins a tie unless fetch has
    // been passed over STARVE_MAX times in a row.
    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        grant_if = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    grant    = 1'b1;
                    grant_if = if_req && (!d_req || (starve_q == STARVE_TOP));
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side strobes, latency counter, read capture and valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 4'b0;
            mem_addr   <= 32'b0;
            mem_wdata  <= 32'b0;
            if_rdata   <= 32'b0;
            d_rdata    <= 32'b0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            lat_cnt_q  <= 2'd0;
            owner_if_q <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            busy     <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        mem_en     <= 1'b1;
                        owner_if_q <= grant_if;
                        if (grant_if) begin
                            mem_addr <= if_addr;
                            mem_we   <= 4'b0;
                        end else begin
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                        end
                    end
                end
                ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 4'b0;
                    lat_cnt_q <= LAT_INIT;
                end
                WAIT: begin
                    if (lat_cnt_q == 2'd0) begin
                        // Writes land here too; the captured word is simply
                        // whatever the macro returns.
                        if (owner_if_q) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            d_rdata <= mem_rdata;
                            d_valid <= 1'b1;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Count data grants that pass over a waiting fetch; any fetch grant clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (grant) begin
            if (grant_if) begin
                starve_q <= '0;
            end else if (if_req && (starve_q != STARVE_TOP)) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: instance 0 with MEM_LAT=1, instance 1 with
// MEM_LAT=3, each backed by a small latency-pipelined memory. A transaction
// level model predicts every output on every cycle from the grant cycle.

module tb_unified_mem_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic [31:0] if_rdata  [2];
    logic        if_valid  [2];
    logic        d_req     [2];
    logic [3:0]  d_we      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic [31:0] d_rdata   [2];
    logic        d_valid   [2];
    logic        mem_en    [2];
    logic [3:0]  mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unified_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) u_a (
        .clk(clk), .rst(rst),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_valid(if_valid[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_valid(d_valid[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .busy(busy[0])
    );

    unified_mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(SMAX)) u_b (
        .clk(clk), .rst(rst),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_valid(if_valid[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_valid(d_valid[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .busy(busy[1])
    );

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] widx(logic [31:0] a);
        return a[9:2];
    endfunction

    function automatic bit fetch_wins(logic ir, logic dr, int st);
        return ir && (!dr || st >= SMAX);
    endfunction

    // Memories: read data appears MEM_LAT cycles after the mem_en cycle.
    logic [31:0] mem_arr [2][256];
    logic [31:0] pipe    [2][4];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int j = 0; j < 256; j++) mem_arr[i][j] <= 32'(32'h1111_0000 * (i + 1) + j);
                if (i == 0) mem_arr[0][64] <= 32'h0000_0013;
                else        mem_arr[1][16] <= 32'hCAFE_F00D;
            end else if (mem_en[i]) begin
                pipe[i][0] <= mem_arr[i][widx(mem_addr[i])];
                for (int b = 0; b < 4; b++)
                    if (mem_we[i][b]) mem_arr[i][widx(mem_addr[i])][8*b +: 8] <= mem_wdata[i][8*b +: 8];
            end
            for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
        end
    end

    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    // Transaction model: grant cycle T, mem_en at T+1, valid at T+2+LAT,
    // idle again at T+3+LAT.
    bit          m_act    [2];
    int          m_start  [2];
    bit          m_own_if [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_wdata  [2];
    logic [31:0] m_rd     [2];
    logic [3:0]  m_we     [2];
    int          m_starve [2];
    logic [31:0] e_if_rd  [2];
    logic [31:0] e_d_rd   [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] <= 1'b0; m_start[i] <= 0; m_own_if[i] <= 1'b0;
                m_addr[i] <= 32'b0; m_wdata[i] <= 32'b0; m_rd[i] <= 32'b0;
                m_we[i] <= 4'b0; m_starve[i] <= 0; e_if_rd[i] <= 32'b0; e_d_rd[i] <= 32'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_act[i]) begin
                    if (if_req[i] || d_req[i]) begin
                        m_act[i]    <= 1'b1;
                        m_start[i]  <= cyc;
                        m_own_if[i] <= fetch_wins(if_req[i], d_req[i], m_starve[i]);
                        if (fetch_wins(if_req[i], d_req[i], m_starve[i])) begin
                            m_addr[i]   <= if_addr[i];
                            m_we[i]     <= 4'b0;
                            m_rd[i]     <= mem_arr[i][widx(if_addr[i])];
                            m_starve[i] <= 0;
                        end else begin
                            m_addr[i]  <= d_addr[i];
                            m_we[i]    <= d_we[i];
                            m_wdata[i] <= d_wdata[i];
                            m_rd[i]    <= mem_arr[i][widx(d_addr[i])];
                            if (if_req[i]) m_starve[i] <= (m_starve[i] + 1 > SMAX) ? SMAX : m_starve[i] + 1;
                        end
                    end
                end else begin
                    if (cyc == m_start[i] + lat_of(i) + 1) begin
                        if (m_own_if[i]) e_if_rd[i] <= m_rd[i];
                        else             e_d_rd[i]  <= m_rd[i];
                    end
                    if (cyc == m_start[i] + lat_of(i) + 2) m_act[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", nm, got, exp, cyc);
        end
    endtask

    // Cycle-by-cycle compare against the model.
    initial begin
        int t, l;
        bit e_en, e_busy, e_ifv, e_dv;
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                t      = m_start[i];
                l      = lat_of(i);
                e_busy = m_act[i] && cyc >= t + 1 && cyc <= t + l + 2;
                e_en   = m_act[i] && cyc == t + 1;
                e_ifv  = m_act[i] && m_own_if[i] && cyc == t + l + 2;
                e_dv   = m_act[i] && !m_own_if[i] && cyc == t + l + 2;
                chk($sformatf("busy%0d", i),      32'(busy[i]),     32'(e_busy));
                chk($sformatf("mem_en%0d", i),    32'(mem_en[i]),   32'(e_en));
                chk($sformatf("mem_we%0d", i),    32'(mem_we[i]),   e_en ? 32'(m_we[i]) : 32'd0);
                chk($sformatf("mem_addr%0d", i),  mem_addr[i],      m_addr[i]);
                chk($sformatf("mem_wdata%0d", i), mem_wdata[i],     m_wdata[i]);
                chk($sformatf("if_valid%0d", i),  32'(if_valid[i]), 32'(e_ifv));
                chk($sformatf("d_valid%0d", i),   32'(d_valid[i]),  32'(e_dv));
                chk($sformatf("if_rdata%0d", i),  if_rdata[i],      e_if_rd[i]);
                chk($sformatf("d_rdata%0d", i),   d_rdata[i],       e_d_rd[i]);
            end
        end
    end

    task automatic goto_cyc(int t);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cyc < t && g < 1000);
        if (cyc != t) chk("goto_cyc", 32'(cyc), 32'(t));
    endtask

    task automatic wait_if_valid(int i);
        int g = 0;
        while (!if_valid[i] && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!if_valid[i]) chk("if_valid_timeout", 32'(if_valid[i]), 32'd1);
    endtask

    // Record fetch(1)/data(0) for the next n grants on instance 0.
    task automatic collect(int n, output bit g_if [16]);
        int got = 0;
        int guard = 0;
        for (int j = 0; j < 16; j++) g_if[j] = 1'b0;
        while (got < n && guard < 500) begin
            @(negedge clk);
            guard++;
            if (mem_en[0]) begin
                g_if[got] = (mem_addr[0] == 32'h300);
                got++;
            end
        end
        if (got < n) chk("grant_timeout", 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        bit  g_if [16];
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if_req[i] = 1'b0; if_addr[i] = 32'b0;
            d_req[i] = 1'b0; d_we[i] = 4'b0; d_addr[i] = 32'b0; d_wdata[i] = 32'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en",   32'(mem_en[0]), 32'd0);
        chk("rst_busy",     32'(busy[1]),   32'd0);
        chk("rst_if_rdata", if_rdata[0],    32'd0);
        chk("rst_mem_addr", mem_addr[1],    32'd0);
        rst = 1'b0;

        // Fetch only, MEM_LAT=1.
        @(posedge clk); #1;
        if_req[0] = 1'b1; if_addr[0] = 32'h100; t0 = cyc;
        goto_cyc(t0 + 1);
        chk("t1_mem_en",   32'(mem_en[0]), 32'd1);
        chk("t1_mem_addr", mem_addr[0],    32'h100);
        chk("t1_busy1",    32'(busy[0]),   32'd1);
        goto_cyc(t0 + 3);
        chk("t1_if_valid", 32'(if_valid[0]), 32'd1);
        chk("t1_if_rdata", if_rdata[0],      32'h13);
        chk("t1_busy3",    32'(busy[0]),     32'd1);
        @(posedge clk); #1;
        if_req[0] = 1'b0;
        goto_cyc(t0 + 4);
        chk("t1_busy4", 32'(busy[0]), 32'd0);

        // Store, MEM_LAT=1.
        @(posedge clk); #1;
        d_req[0] = 1'b1; d_we[0] = 4'b0011; d_addr[0] = 32'h2004; d_wdata[0] = 32'h0000BEEF; t0 = cyc;
        goto_cyc(t0 + 1);
        chk("t2_mem_en",    32'(mem_en[0]), 32'd1);
        chk("t2_mem_we",    32'(mem_we[0]), 32'b0011);
        chk("t2_mem_addr",  mem_addr[0],    32'h2004);
        chk("t2_mem_wdata", mem_wdata[0],   32'h0000BEEF);
        goto_cyc(t0 + 2);
        chk("t2_mem_en_off", 32'(mem_en[0]), 32'd0);
        chk("t2_mem_we_off", 32'(mem_we[0]), 32'd0);
        goto_cyc(t0 + 3);
        chk("t2_d_valid",  32'(d_valid[0]),  32'd1);
        chk("t2_if_valid", 32'(if_valid[0]), 32'd0);
        @(posedge clk); #1;
        d_req[0] = 1'b0; d_we[0] = 4'b0;

        // Back-to-back fetches 0x0 then 0x4.
        @(posedge clk); #1;
        if_req[0] = 1'b1; if_addr[0] = 32'h0; t0 = cyc;
        goto_cyc(t0 + 3);
        chk("t6_if_rdata0", if_rdata[0], 32'h1111_0000);
        @(posedge clk); #1;
        if_addr[0] = 32'h4;
        goto_cyc(t0 + 5);
        chk("t6_mem_en",   32'(mem_en[0]), 32'd1);
        chk("t6_mem_addr", mem_addr[0],    32'h4);
        goto_cyc(t0 + 7);
        chk("t6_if_valid",  32'(if_valid[0]), 32'd1);
        chk("t6_if_rdata1", if_rdata[0],      32'h1111_BEEF);
        @(posedge clk); #1;
        if_req[0] = 1'b0;

        // Load with MEM_LAT=3.
        @(posedge clk); #1;
        d_req[1] = 1'b1; d_addr[1] = 32'h40; d_we[1] = 4'b0; t0 = cyc;
        goto_cyc(t0 + 4);
        chk("t4_d_valid_early", 32'(d_valid[1]), 32'd0);
        goto_cyc(t0 + 5);
        chk("t4_d_valid", 32'(d_valid[1]), 32'd1);
        chk("t4_d_rdata", d_rdata[1],      32'hCAFE_F00D);
        @(posedge clk); #1;
        d_req[1] = 1'b0;
        goto_cyc(t0 + 6);
        chk("t4_d_valid_late", 32'(d_valid[1]), 32'd0);

        // Both requesting continuously: D D D D I D D D D I D D D.
        @(posedge clk); #1;
        if_addr[0] = 32'h300; d_addr[0] = 32'h500; d_we[0] = 4'b0;
        if_req[0] = 1'b1; d_req[0] = 1'b1;
        collect(13, g_if);
        for (int j = 0; j < 13; j++)
            chk($sformatf("t3_grant%0d", j), 32'(g_if[j]), 32'((j == 4) || (j == 9)));

        // Abort the next data transfer in WAIT with starve at 4.
        collect(1, g_if);
        chk("t5_pre_grant", 32'(g_if[0]), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_mem_en_abort", 32'(mem_en[0]), 32'd0);
        chk("t5_busy_abort",   32'(busy[0]),   32'd0);
        repeat (2) @(negedge clk);
        chk("t5_no_d_valid", 32'(d_valid[0]), 32'd0);
        rst = 1'b0;
        collect(5, g_if);
        for (int j = 0; j < 5; j++)
            chk($sformatf("t5_grant%0d", j), 32'(g_if[j]), 32'(j == 4));
        wait_if_valid(0);
        chk("t5_if_rdata", if_rdata[0], 32'h1111_00C0);
        @(posedge clk); #1;
        if_req[0] = 1'b0; d_req[0] = 1'b0;

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
